// File: rtl/parallel2serial_10i.sv
// parallel2serial_10i: captures ten parallel words on an accepted load and
// presents them one per transfer on a valid/ready serial output, in0 first.
// Optional macro P2S_BACKPRESSURE_EN: when defined out_ready gates transfers;
// when undefined out_ready is ignored and every SHIFT cycle is a transfer.
module parallel2serial_10i #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic [WIDTH-1:0] in9,
  input  logic             load,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_buf [NWORDS];
  logic [WIDTH-1:0] w_in  [NWORDS];
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_inc;
  logic [WIDTH-1:0] r_out;
  logic             r_done;
  logic             w_ready;
  logic             w_accept;
  logic             w_xfer;
  logic             w_cnt_last;

  assign w_in[0] = in0;
  assign w_in[1] = in1;
  assign w_in[2] = in2;
  assign w_in[3] = in3;
  assign w_in[4] = in4;
  assign w_in[5] = in5;
  assign w_in[6] = in6;
  assign w_in[7] = in7;
  assign w_in[8] = in8;
  assign w_in[9] = in9;

`ifdef P2S_BACKPRESSURE_EN
  assign w_ready = out_ready;
`else
  // Free-running receiver: the port stays for pin compatibility only.
  logic w_unused_ready;
  assign w_unused_ready = out_ready;
  assign w_ready        = 1'b1;
`endif

  assign w_accept   = (r_state == IDLE) && load;
  assign w_xfer     = (r_state == SHIFT) && w_ready;
  assign w_cnt_last = (r_cnt == 4'(NWORDS - 1));
  assign w_cnt_inc  = r_cnt + 4'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state: start on an accepted load, finish on the word-9 transfer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (load) w_state_next = SHIFT;
      SHIFT:   if (w_xfer && w_cnt_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Frame buffer: all ten words captured together on an accepted load.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NWORDS; i++) begin
      if (rst)           r_buf[i] <= '0;
      else if (w_accept) r_buf[i] <= w_in[i];
    end
  end

  // Word counter, registered output word and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_out  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_xfer && w_cnt_last;
      if (w_accept) begin
        // in0 is taken straight from the port so it is on out next cycle.
        r_cnt <= '0;
        r_out <= w_in[0];
      end else if (w_xfer) begin
        if (w_cnt_last) begin
          r_cnt <= '0;
          r_out <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
          r_out <= r_buf[w_cnt_inc];
        end
      end
    end
  end

  assign out       = r_out;
  assign out_valid = (r_state == SHIFT);
  assign out_last  = (r_state == SHIFT) && w_cnt_last;
  assign busy      = (r_state == SHIFT);
  assign done      = r_done;

endmodule

// File: tb/tb_parallel2serial_10i.sv
// Bench for parallel2serial_10i: a constant-vector table for the basic frame,
// hand sequences for the multi-cycle corner cases, and a random run, all
// cross-checked every cycle against a queue-based frame model.
module tb_parallel2serial_10i;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, load, out_ready;
  logic [W-1:0] words [10];
  logic [W-1:0] out;
  logic         out_valid, out_last, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: words still to be sent in the current frame, plus done flag.
  logic [W-1:0] mq [$];
  bit           mdone = 1'b0;

  always #5 clk = ~clk;

  parallel2serial_10i #(.WIDTH(W), .NWORDS(10)) dut (
    .clk(clk), .rst(rst),
    .in0(words[0]), .in1(words[1]), .in2(words[2]), .in3(words[3]),
    .in4(words[4]), .in5(words[5]), .in6(words[6]), .in7(words[7]),
    .in8(words[8]), .in9(words[9]),
    .load(load), .out_ready(out_ready),
    .out(out), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit ld, input bit rdy, input bit rs);
    bit er, v, nd;
    rst = rs; load = ld; out_ready = rdy;
`ifdef P2S_BACKPRESSURE_EN
    er = rdy;
`else
    er = 1'b1;
`endif
    @(posedge clk);
    cyc++;
    v = (mq.size() != 0);
    if (rs) begin
      mq.delete();
      mdone = 1'b0;
    end else begin
      nd = v && er && (mq.size() == 1);
      if (v && er) void'(mq.pop_front());
      if (!v && ld) for (int i = 0; i < 10; i++) mq.push_back(words[i]);
      mdone = nd;
    end
    #1;
    check("m_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    check("m_out",   out, (mq.size() != 0) ? mq[0] : '0);
    check("m_last",  {31'd0, out_last}, {31'd0, mq.size() == 1});
    check("m_busy",  {31'd0, busy}, {31'd0, mq.size() != 0});
    check("m_done",  {31'd0, done}, {31'd0, mdone});
    $display("cyc=%0d rst=%0b load=%0b rdy=%0b out=%h v=%0b last=%0b busy=%0b done=%0b",
             cyc, rs, ld, rdy, out, out_valid, out_last, busy, done);
  endtask

  task automatic set_frame(input logic [W-1:0] base);
    for (int i = 0; i < 10; i++) words[i] = base + W'(i);
  endtask

  typedef struct {
    bit           ld;
    bit           v;
    logic [W-1:0] o;
    bit           l;
    bit           b;
    bit           d;
  } vec_t;

  vec_t tbl [12];
  logic [W-1:0] rx [10];
  int           n;

  initial begin
    rst = 1'b1; load = 1'b0; out_ready = 1'b1;
    set_frame(32'h0);

    // Reset state.
    step(0, 1, 1);
    step(0, 1, 1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out",   out, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    step(0, 1, 0);

    // Basic frame 0..9: words on 10 cycles, done on the 11th after load.
    tbl[0] = '{1, 1, 32'h0, 0, 1, 0};
    for (int i = 1; i < 10; i++) tbl[i] = '{0, 1, W'(i), (i == 9), 1, 0};
    tbl[10] = '{0, 0, 32'h0, 0, 0, 1};
    tbl[11] = '{0, 0, 32'h0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].ld, 1, 0);
      check($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].v});
      check($sformatf("tbl%0d_out", i),   out, tbl[i].o);
      check($sformatf("tbl%0d_last", i),  {31'd0, out_last}, {31'd0, tbl[i].l});
      check($sformatf("tbl%0d_busy", i),  {31'd0, busy}, {31'd0, tbl[i].b});
      check($sformatf("tbl%0d_done", i),  {31'd0, done}, {31'd0, tbl[i].d});
    end

    // Loopback through a receiver that records every valid word, then a
    // back-to-back load in the done cycle.
    set_frame(32'hA0);
    step(1, 1, 0);
    n = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (out_valid && n < 10) begin rx[n] = out; n++; end
      step(0, 1, 0);
    end
    check("lb_done", {31'd0, done}, 32'd1);
    check("lb_count", n, 10);
    for (int i = 0; i < 10; i++) check($sformatf("lb_out%0d", i), rx[i], 32'hA0 + W'(i));
    check("b2b_gap_valid", {31'd0, out_valid}, 32'd0);
    set_frame(32'h10);
    step(1, 1, 0);
    check("b2b_first", out, 32'h10);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 12; k++) step(0, 1, 0);

    // Load while word 5 is on out is ignored.
    set_frame(32'h0);
    step(1, 1, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0);
    check("ign_at5", out, 32'h5);
    words[0] = 32'hFF;
    step(1, 1, 0);
    check("ign_next", out, 32'h6);
    for (int k = 0; k < 6; k++) begin
      check("ign_noff", {31'd0, out == 32'hFF}, 32'd0);
      step(0, 1, 0);
    end

    // Reset while word 4 is on out.
    set_frame(32'h0);
    step(1, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0);
    check("mrst_at4", out, 32'h4);
    step(0, 1, 1);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_busy",  {31'd0, busy}, 32'd0);
    check("mrst_out",   out, 32'd0);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0);
      check("mrst_nodone", {31'd0, done}, 32'd0);
    end
    set_frame(32'h20);
    step(1, 1, 0);
    check("mrst_fresh", out, 32'h20);
    for (int k = 0; k < 11; k++) step(0, 1, 0);

`ifdef P2S_BACKPRESSURE_EN
    // Stall three cycles with word 3 on out; done lands 3 cycles late.
    set_frame(32'h0);
    step(1, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0);
      check("bp_hold", out, 32'h3);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    step(0, 1, 0);
    check("bp_next", out, 32'h4);
    n = 8;
    while (!done && n < 30) begin step(0, 1, 0); n++; end
    check("bp_done_cycle", n, 14);
    step(0, 1, 0);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 10; i++) words[i] = $urandom;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/parallel2serial_10i.md
PARALLEL2SERIAL_10I -- requirements
Module: parallel2serial_10i

Interface
REQ-001 Parameter WIDTH, default 32: bit width of every data word.
REQ-002 Parameter NWORDS, fixed 10: words per frame. Counter width is 4 bits.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Ports in0..in9, input, WIDTH each: parallel frame words, sampled only on an accepted load.
REQ-006 Port load, input, 1: request to capture in0..in9 and start a frame.
REQ-007 Port out_ready, input, 1: downstream accepts the current word.
REQ-008 Port out, output, WIDTH: current serial word.
REQ-009 Port out_valid, output, 1: out holds a valid word.
REQ-010 Port out_last, output, 1: out holds word 9 of the frame.
REQ-011 Port busy, output, 1: a frame is in progress.
REQ-012 Port done, output, 1: one-cycle pulse after the last word is transferred.

Function
REQ-013 FSM has two states. IDLE to SHIFT on an accepted load. SHIFT to IDLE on the transfer of word 9.
REQ-014 Load is accepted only in IDLE. In SHIFT, load is ignored and the frame in flight is not disturbed.
REQ-015 An accepted load at edge N registers in0..in9 into a 10-entry buffer and clears the 4-bit word counter to 0.
REQ-016 From the cycle after edge N: out_valid=1, out=in0 as captured. Latency from load to first word is 1 cycle.
REQ-017 Serial order is in0 first and in9 last. This matches the shift-in order of the companion serial2parallel_10o, so a loopback restores the original words on out0..out9.
REQ-018 Transfer = out_valid && out_ready at a rising edge. On each transfer the counter increments and out presents the next word on the following cycle.
REQ-019 Without a transfer, out, out_valid and the counter hold their values.
REQ-020 out_last = out_valid && (counter == 9).
REQ-021 busy = 1 in SHIFT, 0 in IDLE.
REQ-022 done is registered. It is 1 for exactly the one cycle after the word-9 transfer, and 0 otherwise.
REQ-023 A load in the done cycle is accepted, because the FSM is already in IDLE. Back-to-back frames therefore have a one-cycle gap (out_valid=0) between word 9 and the next word 0.
REQ-024 The counter never exceeds 9. It does not wrap inside a frame.
REQ-025 In IDLE: out_valid=0, out_last=0, and out holds 0.

Reset
REQ-026 With rst=1 at an edge: FSM goes to IDLE, counter=0, buffer=0, out=0, out_valid=0, out_last=0, busy=0, done=0.
REQ-027 Reset overrides load and any transfer in the same cycle.
REQ-028 A reset in mid-frame discards the frame and does not pulse done.

Configuration
REQ-029 Macro P2S_BACKPRESSURE_EN defined: out_ready is honoured exactly as described in REQ-018.
REQ-030 Macro P2S_BACKPRESSURE_EN undefined: the out_ready port remains present but is ignored and treated as 1. In this case a frame always takes exactly 10 cycles in SHIFT, matching the free-running receiver, and done follows 11 cycles after an accepted load.

Verification
REQ-031 Reset, then load with in0..in9 = 0x00000000..0x00000009 and out_ready held 1.
- out = 0x0, 0x1, …, 0x9 on 10 consecutive cycles starting 1 cycle after load.
- out_last=1 only with 0x9.
- done pulses on the 11th cycle after load.
REQ-032 Loopback: connect out to serial2parallel_10o.in and out_valid to its start, with in0..in9 = 0xA0..0xA9.
- After done, out0..out9 = 0xA0..0xA9.
REQ-033 Backpressure (macro defined): hold out_ready=0 for 3 cycles while out=0x3.
- out stays 0x3 and out_valid stays 1.
- Then 0x4 appears one cycle after out_ready returns to 1.
- done is delayed by 3 cycles.
REQ-034 Assert load again with in0=0xFF while word 0x5 is on out.
- The frame continues 0x6..0x9 unchanged.
- 0xFF never appears.
REQ-035 Assert rst in the cycle word 0x4 is on out.
- The next cycle shows out_valid=0, busy=0 and out=0.
- done never pulses.
- A subsequent load starts a fresh frame at in0.
REQ-036 Back-to-back: load in the done cycle with in0..in9 = 0x10..0x19.
- Exactly one cycle with out_valid=0, then 0x10 appears.
